bp_commit_perf_mon: RTL and testbench

BP_COMMIT_PERF_MON -- requirements
Module: bp_commit_perf_mon

---
 rtl/bp_commit_perf_mon.sv | 132 +++++++++++++
 tb/tb_bp_commit_perf_mon.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_commit_perf_mon.sv
// Commit-stage performance monitor: counts retired and stalled
// cycles between boot completion and test end, with a no-commit watchdog.
module bp_commit_perf_mon #(
  parameter int cnt_width_p       = 30,
  parameter int boot_addr_width_p = 9,
  parameter int boot_done_addr_p  = 511,
  parameter int watchdog_p        = 65535
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [boot_addr_width_p-1:0] boot_rom_addr_i,
  input  logic                         cmt_exc_v_i,
  input  logic                         fe_nop_v_i,
  input  logic                         be_nop_v_i,
  input  logic                         me_nop_v_i,
  input  logic                         test_done_i,
  output logic [cnt_width_p-1:0]       instr_cnt_o,
  output logic [cnt_width_p-1:0]       clock_cnt_o,
  output logic [cnt_width_p-1:0]       stall_cnt_o,
  output logic [2:0]                   state_o,
  output logic                         report_v_o,
  input  logic                         report_yumi_i,
  output logic                         timeout_o
);

  localparam int wd_w = $clog2(watchdog_p + 1);

  localparam logic [wd_w-1:0] wd_max =
    wd_w'(watchdog_p);

  localparam logic [cnt_width_p-1:0] cnt_max = '1;

  localparam logic [boot_addr_width_p-1:0] boot_done =
    boot_addr_width_p'(boot_done_addr_p);

  typedef enum logic [2:0] {
    e_wait_boot = 3'd0,
    e_run       = 3'd1,
    e_report    = 3'd2,
    e_halt      = 3'd3
  } state_e;

  state_e state_q, state_d;

  logic [cnt_width_p-1:0] instr_q, instr_d;
  logic [cnt_width_p-1:0] clock_q, clock_d;
  logic [cnt_width_p-1:0] stall_q, stall_d;
  logic [wd_w-1:0]        wd_q, wd_d, wd_inc;
  logic                   timeout_q, timeout_d;
  logic                   retire;
  logic                   wd_hit;

  function automatic logic [cnt_width_p-1:0] sat_inc(
    input logic [cnt_width_p-1:0] v
  );
    return (v == cnt_max) ? v : v + cnt_width_p'(1);
  endfunction

  assign retire = ~(cmt_exc_v_i | fe_nop_v_i |
                    be_nop_v_i  | me_nop_v_i);

  assign wd_inc = wd_q + wd_w'(1);
  assign wd_hit = ~retire & (wd_inc == wd_max);

  // Next-state, counter and watchdog update; test_done beats watchdog.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    clock_d   = clock_q;
    stall_d   = stall_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    unique case (state_q)
      e_wait_boot: begin
        if (boot_rom_addr_i == boot_done) state_d = e_run;
      end
      e_run: begin
        clock_d = sat_inc(clock_q);
        if (retire) begin
          instr_d = sat_inc(instr_q);
          wd_d    = '0;
        end else begin
          stall_d = sat_inc(stall_q);
          wd_d    = wd_inc;
        end
        if (test_done_i) begin
          state_d   = e_report;
          timeout_d = 1'b0;
        end else if (wd_hit) begin
          state_d   = e_report;
          timeout_d = 1'b1;
        end
      end
      e_report: begin
        if (report_yumi_i) state_d = e_halt;
      end
      e_halt: begin
        state_d = e_halt;
      end
      default: begin
        state_d = e_wait_boot;
      end
    endcase
  end

  // State and counter registers, cleared asynchronously on reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= e_wait_boot;
      instr_q   <= '0;
      clock_q   <= '0;
      stall_q   <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      clock_q   <= clock_d;
      stall_q   <= stall_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign instr_cnt_o = instr_q;
  assign clock_cnt_o = clock_q;
  assign stall_cnt_o = stall_q;
  assign state_o     = state_q;
  assign report_v_o  = (state_q == e_report);
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_bp_commit_perf_mon.sv
// Bench for bp_commit_perf_mon: two instances (wide counters,
// and 4-bit counters with an 8-cycle watchdog) on shared stimulus.
module tb_bp_commit_perf_mon;

  logic       clk;
  logic       rst_n;
  logic [8:0] boot_addr;
  logic       exc, fe_nop, be_nop, me_nop;
  logic       done;
  logic       yumi;

  logic [29:0] instr_a, clock_a, stall_a;
  logic [2:0]  state_a;
  logic        rv_a, to_a;

  logic [3:0]  instr_b, clock_b, stall_b;
  logic [2:0]  state_b;
  logic        rv_b, to_b;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int instr;
    int clk;
    int stall;
    int to;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic rv_a_q = 1'b0;
  logic rv_b_q = 1'b0;

  bp_commit_perf_mon dut_a (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .boot_rom_addr_i (boot_addr),
    .cmt_exc_v_i     (exc),
    .fe_nop_v_i      (fe_nop),
    .be_nop_v_i      (be_nop),
    .me_nop_v_i      (me_nop),
    .test_done_i     (done),
    .instr_cnt_o     (instr_a),
    .clock_cnt_o     (clock_a),
    .stall_cnt_o     (stall_a),
    .state_o         (state_a),
    .report_v_o      (rv_a),
    .report_yumi_i   (yumi),
    .timeout_o       (to_a)
  );

  bp_commit_perf_mon #(
    .cnt_width_p (4),
    .watchdog_p  (8)
  ) dut_b (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .boot_rom_addr_i (boot_addr),
    .cmt_exc_v_i     (exc),
    .fe_nop_v_i      (fe_nop),
    .be_nop_v_i      (be_nop),
    .me_nop_v_i      (me_nop),
    .test_done_i     (done),
    .instr_cnt_o     (instr_b),
    .clock_cnt_o     (clock_b),
    .stall_cnt_o     (stall_b),
    .state_o         (state_b),
    .report_v_o      (rv_b),
    .report_yumi_i   (yumi),
    .timeout_o       (to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Scoreboard: pop one expected report per rising report_v.
  always @(negedge clk) begin
    exp_t e;
    if (rv_a && !rv_a_q) begin
      if (q_a.size() == 0) begin
        chk("sb_a_unexpected", 1, 0);
      end else begin
        e = q_a.pop_front();
        chk("sb_a_instr", instr_a, e.instr);
        chk("sb_a_clock", clock_a, e.clk);
        chk("sb_a_stall", stall_a, e.stall);
        chk("sb_a_timeout", to_a, e.to);
      end
    end
    if (rv_b && !rv_b_q) begin
      if (q_b.size() == 0) begin
        chk("sb_b_unexpected", 1, 0);
      end else begin
        e = q_b.pop_front();
        chk("sb_b_instr", instr_b, e.instr);
        chk("sb_b_clock", clock_b, e.clk);
        chk("sb_b_stall", stall_b, e.stall);
        chk("sb_b_timeout", to_b, e.to);
      end
    end
    rv_a_q = rv_a;
    rv_b_q = rv_b;
  end

  task automatic push(
    input int ai, input int ac, input int as, input int at,
    input int bi, input int bc, input int bs, input int bt
  );
    q_a.push_back('{instr: ai, clk: ac, stall: as, to: at});
    q_b.push_back('{instr: bi, clk: bc, stall: bs, to: bt});
  endtask

  task automatic boot();
    boot_addr = 9'd511;
    @(negedge clk);
    boot_addr = 9'd0;
    chk("boot_run", state_a, 1);
  endtask

  task automatic start();
    exc = 0; fe_nop = 0; be_nop = 0; me_nop = 0;
    done = 0; yumi = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    boot();
  endtask

  task automatic end_test();
    done = 1;
    @(negedge clk);
    done = 0;
  endtask

  task automatic wait_rep();
    int n = 0;
    while (!rv_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("report_wait", rv_a, 1);
  endtask

  task automatic release_rep();
    yumi = 1;
    @(negedge clk);
    yumi = 0;
    chk("halt_state", state_a, 3);
    chk("halt_rv", rv_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 0; boot_addr = 0; exc = 0;
    fe_nop = 0; be_nop = 0; me_nop = 0;
    done = 0; yumi = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", state_a, 0);
    chk("rst_instr", instr_a, 0);
    chk("rst_clock", clock_a, 0);
    chk("rst_stall", stall_a, 0);
    chk("rst_rv", rv_a, 0);
    chk("rst_timeout", to_a, 0);
    rst_n = 1;

    // 100 retiring cycles plus the done cycle
    push(101, 101, 0, 0, 15, 15, 0, 0);
    repeat (5) @(negedge clk);
    end_test();
    chk("done_in_boot_state", state_a, 0);
    chk("done_in_boot_clock", clock_a, 0);
    repeat (4) @(negedge clk);
    boot();
    repeat (100) @(negedge clk);
    end_test();
    wait_rep();
    chk("sat_instr_b", instr_b, 15);
    exc = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rv", rv_a, 1);
      chk("hold_instr", instr_a, 101);
      chk("hold_clock", clock_a, 101);
    end
    exc = 0;
    release_rep();
    chk("halt_instr", instr_a, 101);
    done = 1; yumi = 1; boot_addr = 9'd511;
    repeat (3) @(negedge clk);
    done = 0; yumi = 0; boot_addr = 0;
    chk("halt_sticky", state_a, 3);
    chk("halt_clock", clock_a, 101);

    // alternating be_nop: 20 stalls, 20+1 retires
    push(21, 41, 20, 0, 15, 15, 15, 0);
    start();
    for (int i = 0; i < 40; i++) begin
      be_nop = i[0];
      @(negedge clk);
    end
    be_nop = 0;
    end_test();
    wait_rep();
    release_rep();

    // watchdog expiry on the 4-bit instance
    push(0, 11, 11, 0, 0, 8, 8, 1);
    start();
    exc = 1;
    repeat (8) @(negedge clk);
    chk("wd_b_state", state_b, 2);
    chk("wd_a_running", state_a, 1);
    repeat (2) @(negedge clk);
    end_test();
    exc = 0;
    wait_rep();
    chk("wd_b_held", stall_b, 8);
    release_rep();

    // done and watchdog in the same cycle: done wins
    push(0, 8, 8, 0, 0, 8, 8, 0);
    start();
    exc = 1;
    repeat (7) @(negedge clk);
    end_test();
    exc = 0;
    wait_rep();
    chk("tie_b_timeout", to_b, 0);
    release_rep();

    // asynchronous reset mid-run
    start();
    repeat (5) @(negedge clk);
    chk("pre_rst_instr", instr_a, 5);
    #2;
    rst_n = 0;
    #1;
    chk("arst_instr", instr_a, 0);
    chk("arst_clock", clock_a, 0);
    chk("arst_state", state_a, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    chk("post_rst_wait", state_a, 0);
    chk("post_rst_clock", clock_a, 0);
    push(4, 4, 0, 0, 4, 4, 0, 0);
    boot();
    repeat (3) @(negedge clk);
    end_test();
    wait_rep();
    release_rep();

    @(negedge clk);
    chk("sb_a_left", q_a.size(), 0);
    chk("sb_b_left", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
